// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key expansion: one round key per cycle into a bank with an indexed read port.
// Key k is ready k edges after accept. Loads are refused (key_ready_o=0) and ignored while expanding.

module aes_key_shedualing (
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_next_o,
    output logic [7:0]   key_rcon_o
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as x^254 (squares x^2..x^128 multiplied together); 0 maps to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] rot_w;
    logic [31:0] temp_w;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        rot_w  = {key_i[23:0], key_i[31:24]};
        temp_w = {sbox(rot_w[31:24]) ^ rcon_i, sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        n0 = key_i[127:96] ^ temp_w;
        n1 = key_i[95:64]  ^ n0;
        n2 = key_i[63:32]  ^ n1;
        n3 = key_i[31:0]   ^ n2;
        key_next_o = {n0, n1, n2, n3};
        key_rcon_o = xtime(rcon_i);
    end
endmodule

module aes_key_expand_ctrl #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             key_valid_i,
    input  logic [127:0]     key_i,
    output logic             key_ready_o,
    output logic             busy_o,
    output logic             done_o,
    input  logic [IDX_W-1:0] rk_idx_i,
    output logic [127:0]     rk_o,
    output logic             rk_valid_o
);
    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [7:0]         rcon_q;
    logic [NR:0]        valid_q;
    logic               key_ready_q;
    logic               busy_q;
    logic               done_q;
    logic [127:0]       wkey_q;
    logic [127:0]       bank_q [0:NR];

    logic [127:0]       key_next;
    logic [7:0]         rcon_next;
    logic               load_acc;

    assign load_acc = key_valid_i & key_ready_q;

    aes_key_shedualing u_sched (
        .key_i      (wkey_q),
        .rcon_i     (rcon_q),
        .key_next_o (key_next),
        .key_rcon_o (rcon_next)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rcon_q      <= 8'h01;
            valid_q     <= '0;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (load_acc) begin
            state_q     <= S_EXPAND;
            cnt_q       <= IDX_W'(1);
            rcon_q      <= 8'h01;
            valid_q     <= {{NR{1'b0}}, 1'b1};
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else if (state_q == S_EXPAND) begin
            valid_q[cnt_q] <= 1'b1;
            rcon_q         <= rcon_next;
            if (cnt_q == IDX_W'(NR)) begin
                state_q     <= S_DONE;
                key_ready_q <= 1'b1;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
            end else begin
                cnt_q <= cnt_q + IDX_W'(1);
            end
        end
    end

    // Storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            bank_q[0] <= key_i;
            wkey_q    <= key_i;
        end else if (state_q == S_EXPAND) begin
            bank_q[cnt_q] <= key_next;
            wkey_q        <= key_next;
        end
    end

    always_comb begin
        rk_o       = '0;
        rk_valid_o = 1'b0;
        if ((rk_idx_i <= IDX_W'(NR)) && valid_q[rk_idx_i]) begin
            rk_o       = bank_q[rk_idx_i];
            rk_valid_o = 1'b1;
        end
    end

    assign key_ready_o = key_ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl: FIPS-197 vectors plus random keys against a word-level key schedule model.
module tb_aes_key_expand_ctrl;
    logic         clk;
    logic         nreset;
    logic         key_valid_i;
    logic [127:0] key_i;
    logic         key_ready_o;
    logic         busy_o;
    logic         done_o;
    logic [3:0]   rk_idx_i;
    logic [127:0] rk_o;
    logic         rk_valid_o;

    int checks = 0;
    int errors = 0;

    aes_key_expand_ctrl #(.NR(10), .IDX_W(4)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .key_valid_i (key_valid_i),
        .key_i       (key_i),
        .key_ready_o (key_ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rk_idx_i    (rk_idx_i),
        .rk_o        (rk_o),
        .rk_valid_o  (rk_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic [7:0]   alog [0:255];
    int           lg   [0:255];
    logic [7:0]   sb   [0:255];
    logic [7:0]   rc   [0:9];
    logic [127:0] mrk  [0:10];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // S-box from log/antilog tables over generator 3 and the bitwise affine formula.
    task automatic build_tables();
        logic [7:0] e;
        logic [7:0] inv;
        logic [7:0] s;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = e;
            lg[e]   = i;
            e = e ^ ({e[6:0], 1'b0} ^ (e[7] ? 8'h1b : 8'h00));
        end
        for (int x = 0; x < 256; x++) begin
            inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ ((8'h63 >> b) & 1);
            sb[x] = s;
        end
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]] ^ rc[i/4-1], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] k);
        key_valid_i = 1'b1;
        key_i       = k;
        tick();
        key_valid_i = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int idx, input logic exp_v, input logic [127:0] exp_d);
        rk_idx_i = 4'(idx);
        #1;
        check({tag, "_vld"}, rk_valid_o, exp_v);
        check({tag, "_dat"}, rk_o, exp_d);
    endtask

    initial begin
        logic [127:0] rkey;
        int           idx;
        build_tables();
        nreset = 1'b0; key_valid_i = 1'b0; key_i = '0; rk_idx_i = '0;
        #12;
        check("rst_ready", key_ready_o, 1'b1);
        check("rst_busy",  busy_o, 1'b0);
        check("rst_done",  done_o, 1'b0);
        check("rst_rkvld", rk_valid_o, 1'b0);
        check("rst_rk",    rk_o, 128'h0);
        @(negedge clk);
        nreset = 1'b1;
        tick();

        // FIPS key: latency, early read of index 3, junk load ignored mid-expansion
        model_expand(FIPS_KEY);
        rk_idx_i = 4'd3;
        load(FIPS_KEY);
        for (int c = 0; c <= 10; c++) begin
            check("lat_busy",  busy_o, c < 10);
            check("lat_ready", key_ready_o, c == 10);
            check("lat_done",  done_o, c == 10);
            check("early_vld", rk_valid_o, c >= 3);
            if (c >= 3) check("early_rk3", rk_o, FIPS_RK3);
            key_valid_i = (c == 4);
            key_i       = '0;
            if (c < 10) tick();
        end
        key_valid_i = 1'b0;
        read_chk("fips_rk1", 1, 1'b1, FIPS_RK1);
        read_chk("fips_rk10", 10, 1'b1, FIPS_RK10);
        for (int r = 0; r <= 10; r++) read_chk("fips_model", r, 1'b1, mrk[r]);
        tick(); tick();
        check("done_hold", done_o, 1'b1);

        read_chk("idx11", 11, 1'b0, 128'h0);
        read_chk("idx15", 15, 1'b0, 128'h0);

        // Reload all-zero key from DONE
        model_expand(128'h0);
        load(128'h0);
        check("reload_done", done_o, 1'b0);
        read_chk("reload_rk1_early", 1, 1'b0, 128'h0);
        tick();
        read_chk("reload_rk1", 1, 1'b1, mrk[1]);
        for (int c = 1; c < 10; c++) tick();
        check("zero_done", done_o, 1'b1);
        read_chk("zero_rk10", 10, 1'b1, ZERO_RK10);

        // Reset in the middle of expansion
        load(FIPS_KEY);
        for (int c = 0; c < 4; c++) tick();
        nreset = 1'b0;
        #1;
        check("mid_rst_done",  done_o, 1'b0);
        check("mid_rst_ready", key_ready_o, 1'b1);
        check("mid_rst_busy",  busy_o, 1'b0);
        for (int r = 0; r <= 10; r++) read_chk("mid_rst_rk", r, 1'b0, 128'h0);
        #2;
        nreset = 1'b1;
        tick();
        read_chk("post_rst_rk0", 0, 1'b0, 128'h0);
        model_expand(FIPS_KEY);
        load(FIPS_KEY);
        for (int c = 0; c < 10; c++) tick();
        check("post_rst_done", done_o, 1'b1);
        read_chk("post_rst_rk10", 10, 1'b1, FIPS_RK10);

        // Random keys, random read indices, random ignored loads during expansion
        for (int it = 0; it < 6; it++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rkey);
            load(rkey);
            for (int c = 0; c <= 12; c++) begin
                idx = $urandom_range(0, 15);
                read_chk("rnd_rk", idx, (idx <= 10) && (idx <= c),
                         ((idx <= 10) && (idx <= c)) ? mrk[idx] : 128'h0);
                check("rnd_done", done_o, c >= 10);
                key_valid_i = (c < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
                key_i       = {$urandom, $urandom, $urandom, $urandom};
                tick();
            end
            key_valid_i = 1'b0;
            for (int r = 0; r <= 10; r++) read_chk("rnd_final", r, 1'b1, mrk[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
